// File: rtl/class_ovc_allocator.sv
// rtl/class_ovc_allocator.sv - class-restricted output VC allocator with round-robin requester arbitration
module class_ovc_allocator #(
  parameter int C = 4,
  parameter int V = 4,
  parameter int N = 4,
  parameter logic [((C > 1) ? C*V : V)-1:0] CLASS_SETTING = '1,
  parameter int Cw  = (C > 1) ? $clog2(C) : 1,
  parameter int BCw = $clog2(V + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*Cw-1:0] class_in,
  input  logic [V-1:0]   ovc_release,
  output logic [N-1:0]   grant,
  output logic [V-1:0]   granted_ovc,
  output logic [V-1:0]   ovc_busy,
  output logic [BCw-1:0] busy_count,
  output logic           class_err
);

  localparam int RRW = (N > 1) ? $clog2(N) : 1;

  logic [RRW-1:0] rr;
  logic [V-1:0]   cand [N];
  logic [N-1:0]   bad;
  logic [N-1:0]   elig;

  logic           found;
  logic [RRW-1:0] win;
  logic [V-1:0]   win_avail;
  logic [V-1:0]   sel_vc;
  int             idx;

  logic [N-1:0]   grant_nxt;
  logic [V-1:0]   busy_nxt;
  logic [BCw-1:0] cnt_nxt;
  logic [RRW-1:0] rr_nxt;

  // A requester is flagged bad until its class matches a legal class index.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      cand[n] = '0;
      bad[n]  = 1'b0;
      if (C <= 1) begin
        cand[n] = '1;
      end else begin
        bad[n] = req[n];
        for (int c = 0; c < C; c++) begin
          if (class_in[n*Cw +: Cw] == Cw'(c)) begin
            cand[n] = CLASS_SETTING[c*V +: V];
            bad[n]  = 1'b0;
          end
        end
      end
      elig[n] = req[n] & ~grant[n] & (|(cand[n] & ~ovc_busy));
    end
  end

  // Round-robin search from rr; VC choice uses registered busy so a VC
  // released this cycle is not handed out until the next one.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_avail = '0;
    sel_vc    = '0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr) + i) % N;
      if (!found && elig[idx]) begin
        found     = 1'b1;
        win       = RRW'(idx);
        win_avail = cand[idx] & ~ovc_busy;
      end
    end
    for (int v = V - 1; v >= 0; v--) begin
      if (win_avail[v]) begin
        sel_vc    = '0;
        sel_vc[v] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_nxt = found ? (N'(1) << win) : '0;
    busy_nxt  = (ovc_busy & ~ovc_release) | sel_vc;
    rr_nxt    = rr;
    if (found) begin
      rr_nxt = (win == RRW'(N - 1)) ? '0 : win + RRW'(1);
    end
    cnt_nxt = '0;
    for (int v = 0; v < V; v++) begin
      cnt_nxt = cnt_nxt + BCw'(busy_nxt[v]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      granted_ovc <= '0;
      ovc_busy    <= '0;
      busy_count  <= '0;
      class_err   <= 1'b0;
      rr          <= '0;
    end else begin
      grant       <= grant_nxt;
      granted_ovc <= sel_vc;
      ovc_busy    <= busy_nxt;
      busy_count  <= cnt_nxt;
      class_err   <= |bad;
      rr          <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_class_ovc_allocator.sv
// tb/tb_class_ovc_allocator.sv - directed self-checking bench for class_ovc_allocator
module tb_class_ovc_allocator;

  logic       clk;
  logic       reset;

  // main instance: C=2, V=4, N=3, class0 -> VC0/1, class1 -> VC2/3
  logic [2:0] req;
  logic [2:0] class_in;
  logic [3:0] ovc_release;
  logic [2:0] grant;
  logic [3:0] granted_ovc;
  logic [3:0] ovc_busy;
  logic [2:0] busy_count;
  logic       class_err;

  // second instance: C=3 so a 2-bit class field can carry the illegal value 3
  logic [2:0] req_b;
  logic [5:0] class_b;
  logic [3:0] rel_b;
  logic [2:0] grant_b;
  logic [3:0] gov_b;
  logic [3:0] busy_b;
  logic [2:0] count_b;
  logic       class_err_b;

  int checks = 0;
  int errors = 0;

  class_ovc_allocator #(.C(2), .V(4), .N(3), .CLASS_SETTING(8'hC3)) dut (
    .clk(clk), .reset(reset), .req(req), .class_in(class_in),
    .ovc_release(ovc_release), .grant(grant), .granted_ovc(granted_ovc),
    .ovc_busy(ovc_busy), .busy_count(busy_count), .class_err(class_err)
  );

  class_ovc_allocator #(.C(3), .V(4), .N(3), .CLASS_SETTING(12'hFC3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .class_in(class_b),
    .ovc_release(rel_b), .grant(grant_b), .granted_ovc(gov_b),
    .ovc_busy(busy_b), .busy_count(count_b), .class_err(class_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = '0; class_in = '0; ovc_release = '0;
    req_b = '0; class_b = '0; rel_b = '0;

    #12;
    chk("rst_grant", grant, 0);
    chk("rst_gov", granted_ovc, 0);
    chk("rst_busy", ovc_busy, 0);
    chk("rst_count", busy_count, 0);
    chk("rst_cerr", class_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // single request
    req = 3'b001; class_in = 3'b000;
    step();
    chk("single_grant", grant, 3'b001);
    chk("single_gov", granted_ovc, 4'b0001);
    chk("single_busy", ovc_busy, 4'b0001);
    chk("single_count", busy_count, 1);
    req = 3'b000; ovc_release = 4'b0001;
    step();
    ovc_release = 4'b0000;
    chk("single_idle_grant", grant, 0);
    chk("single_rel_busy", ovc_busy, 0);
    chk("single_rel_count", busy_count, 0);

    // reset between edges to bring rr back to 0
    #2 reset = 1'b0;
    #1 reset = 1'b1;

    // contention among three class0 requesters
    req = 3'b111;
    step();
    chk("cont_g0", grant, 3'b001);
    chk("cont_v0", granted_ovc, 4'b0001);
    req = 3'b110;
    step();
    chk("cont_g1", grant, 3'b010);
    chk("cont_v1", granted_ovc, 4'b0010);
    chk("cont_busy", ovc_busy, 4'b0011);
    chk("cont_count", busy_count, 2);
    chk("cont_cerr", class_err, 0);
    req = 3'b100;
    step();
    chk("cont_wait0", grant, 0);
    chk("cont_wait0_gov", granted_ovc, 0);
    step();
    chk("cont_wait1", grant, 0);
    ovc_release = 4'b0001;
    step();
    ovc_release = 4'b0000;
    chk("cont_rel_grant", grant, 0);
    chk("cont_rel_busy", ovc_busy, 4'b0010);
    chk("cont_rel_count", busy_count, 1);
    step();
    chk("cont_g2", grant, 3'b100);
    chk("cont_v2", granted_ovc, 4'b0001);
    chk("cont_busy2", ovc_busy, 4'b0011);
    chk("cont_rr", dut.rr, 0);
    req = 3'b000;
    step();
    chk("cont_idle", grant, 0);

    // class isolation: r0 in class1 while VC0/1 busy
    class_in = 3'b001; req = 3'b001;
    step();
    chk("iso_grant", grant, 3'b001);
    chk("iso_gov", granted_ovc, 4'b0100);
    chk("iso_busy", ovc_busy, 4'b0111);
    chk("iso_count", busy_count, 3);
    req = 3'b000; class_in = 3'b000;
    step();

    // all class0 VCs busy, then release coinciding with a pending request
    req = 3'b010;
    step();
    chk("full_wait0", grant, 0);
    step();
    chk("full_wait1", grant, 0);
    ovc_release = 4'b0001;
    step();
    ovc_release = 4'b0000;
    chk("simul_nogrant", grant, 0);
    chk("simul_busy", ovc_busy, 4'b0110);
    step();
    chk("simul_grant", grant, 3'b010);
    chk("simul_gov", granted_ovc, 4'b0001);
    chk("simul_count", busy_count, 3);
    req = 3'b000;
    step();

    // reset asserted while a grant is being presented
    ovc_release = 4'b0010;
    step();
    ovc_release = 4'b0000;
    req = 3'b010;
    step();
    chk("mid_grant", grant, 3'b010);
    chk("mid_gov", granted_ovc, 4'b0010);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_gov", granted_ovc, 0);
    chk("mid_rst_busy", ovc_busy, 0);
    chk("mid_rst_count", busy_count, 0);
    chk("mid_rst_rr", dut.rr, 0);
    @(posedge clk); #1;
    chk("mid_held_grant", grant, 0);
    reset = 1'b1;
    step();
    chk("mid_resume_grant", grant, 3'b010);
    chk("mid_resume_gov", granted_ovc, 4'b0001);
    chk("mid_resume_busy", ovc_busy, 4'b0001);
    req = 3'b000;
    step();

    // bad class on the C=3 instance: r1 carries class 3
    class_b = 6'b01_11_00; req_b = 3'b111;
    step();
    chk("bad_cerr0", class_err_b, 1);
    chk("bad_grant0", grant_b, 3'b001);
    chk("bad_gov0", gov_b, 4'b0001);
    req_b = 3'b110;
    step();
    chk("bad_cerr1", class_err_b, 1);
    chk("bad_grant1", grant_b, 3'b100);
    chk("bad_gov1", gov_b, 4'b0100);
    req_b = 3'b010;
    step();
    chk("bad_cerr2", class_err_b, 1);
    chk("bad_grant2", grant_b, 0);
    chk("bad_busy", busy_b, 4'b0101);
    req_b = 3'b000;
    step();
    chk("bad_cerr_off", class_err_b, 0);
    chk("bad_grant3", grant_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/class_ovc_allocator.md
CLASS_OVC_ALLOCATOR -- requirements
Module: class_ovc_allocator

Interface
REQ-001 SHALL have parameter C, default 4: number of message classes; C of 0 or 1 means classless.
REQ-002 SHALL have parameter V, default 4: output VCs managed.
REQ-003 SHALL have parameter N, default 4: number of requesters.
REQ-004 SHALL have parameter CLASS_SETTING, default all ones, width C*V (V when C is 0): bits [(i+1)*V-1:i*V] are the VCs class i may use.
REQ-005 SHALL define derived widths Cw = log2(C) when C>1, else 1, and BCw = log2(V+1).
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low; 0 resets all state immediately.
REQ-008 SHALL have port req, input, N: per-requester request; held high until its grant bit is seen.
REQ-009 SHALL have port class_in, input, N*Cw: requester n class at [(n+1)*Cw-1:n*Cw].
REQ-010 SHALL have port ovc_release, input, V: one-cycle pulse per VC; the tail flit has left, so the VC is freed.
REQ-011 SHALL have port grant, output, N: registered one-hot-or-zero grant.
REQ-012 SHALL have port granted_ovc, output, V: registered one-hot VC for the current grant; 0 when there is no grant.
REQ-013 SHALL have port ovc_busy, output, V: registered ownership vector.
REQ-014 SHALL have port busy_count, output, BCw: registered population count of ovc_busy.
REQ-015 SHALL have port class_err, output, 1: registered one-cycle pulse when any active requester has class_in >= C (C>1 only).

Function
REQ-016 SHALL compute cand[n] each cycle as CLASS_SETTING slice for class_in[n]; cand[n] is all ones when C is 0 or 1; cand[n] is 0 when class_in[n] >= C.
REQ-017 SHALL treat requester n as eligible when req[n]=1, grant[n]=0 (requester not in its grant cycle), and (cand[n] & ~ovc_busy) is nonzero.
REQ-018 SHALL choose at most one winner per cycle among eligible requesters, round-robin, starting the search at pointer rr (width log2(N)) and wrapping N-1 to 0.
REQ-019 SHALL select for the winner the lowest-index VC in cand & ~ovc_busy.
REQ-020 SHALL, on the next edge, assert grant[winner]=1 and granted_ovc=the selected VC, set that ovc_busy bit, and set rr to winner+1 modulo N; latency from req to grant is 1 cycle minimum.
REQ-021 SHALL drive grant and granted_ovc to 0 on the next edge when there is no eligible requester; rr then holds.
REQ-022 SHALL clear ovc_busy[v] on the edge after ovc_release[v]=1.
REQ-023 SHALL NOT let a VC released in cycle t be allocated in cycle t; it is first allocatable in t+1.
REQ-024 SHALL ignore release of a VC that is not busy; no error.
REQ-025 SHALL keep requesters with no free candidate VC waiting without bound, with no starvation among requesters sharing a class (round-robin fairness).
REQ-026 SHALL update busy_count every edge to popcount of the next ovc_busy, ranging 0..V.
REQ-027 SHALL ignore req on an already-busy VC set; when all V are busy, grant stays 0 until a release.
REQ-028 SHALL pulse class_err for one cycle per offending cycle; the offending requester is never granted.

Reset
REQ-029 SHALL, while reset=0, force grant=0, granted_ovc=0, ovc_busy=0, busy_count=0, class_err=0 and rr=0 asynchronously.
REQ-030 SHALL discard any in-flight grant when reset asserts mid-operation; allocation resumes from rr=0 on the first edge after release.

Verification (C=2, V=4, N=3, CLASS_SETTING=8'hC3: class0 uses VCs 0,1; class1 uses VCs 2,3)
REQ-031 SHALL check single request: req=001, class0 gives grant=001 and granted_ovc=0001 one cycle later, ovc_busy=0001 and busy_count=1.
REQ-032 SHALL check contention: req=111, all class0, rr=0 gives grants to r0 (VC0) then r1 (VC1); r2 then waits with grant=0 until ovc_release=0001, is granted VC0 two cycles after the pulse, and rr=0 afterwards.
REQ-033 SHALL check class isolation: VCs 0,1 busy and r0 class1 gives grant to VC2 (0100), ovc_busy=0111.
REQ-034 SHALL check a bad class: r1 class_in=3 with req high gives class_err pulse each cycle, grant[1] never set, and other requesters unaffected.
REQ-035 SHALL check simultaneous release and request: ovc_release=0001 with all class0 VCs busy gives no grant that cycle and a grant of VC0 the next cycle.
REQ-036 SHALL check reset mid-operation: reset=0 asynchronously while grant=010 gives all outputs 0 immediately, with no grant until req is re-sampled.
